// File: rtl/fft_feed_pkg.sv
// Shared types and helpers for the FFT frame feeder: FSM state encoding,
// supported transform-length limits and the length clamp.
package fft_feed_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2
  } state_t;

  localparam int DEF_MIN_LOG2_PTS = 6;
  localparam int DEF_MAX_LOG2_PTS = 12;

  function automatic logic [3:0] clamp_log2(input logic [3:0] req,
                                            input logic [3:0] lo,
                                            input logic [3:0] hi);
    if (req < lo) return lo;
    if (req > hi) return hi;
    return req;
  endfunction

endpackage

// File: rtl/st_out_reg.sv
// One-deep registered valid/ready stage. Loads whenever it is empty or its
// contents are being taken this cycle, so it sustains one beat per cycle.
module st_out_reg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_valid,
  input  logic [W-1:0] ld_data,
  output logic         stage_free,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign stage_free = !valid_q || out_ready;
  assign out_valid  = valid_q;
  assign out_data   = data_q;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (stage_free) begin
      valid_d = ld_valid;
      if (ld_valid) data_d = ld_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Frames a continuous sample stream into Avalon-ST packets for the FFT sink:
// sop/eop generation, per-frame length and direction, zero-padding on flush.
module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int IN_W         = 16,
  parameter int OUT_W        = 16,
  parameter int MAX_LOG2_PTS = DEF_MAX_LOG2_PTS,
  parameter int MIN_LOG2_PTS = DEF_MIN_LOG2_PTS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            cfg_log2_pts,
  input  logic                  cfg_inverse,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  sink_valid,
  input  logic                  sink_ready,
  output logic                  sink_sop,
  output logic                  sink_eop,
  output logic [OUT_W-1:0]      sink_real,
  output logic [OUT_W-1:0]      sink_imag,
  output logic [MAX_LOG2_PTS:0] sink_fftpts,
  output logic                  sink_inverse,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam int CW = MAX_LOG2_PTS;
  localparam int PW = MAX_LOG2_PTS + 1;
  localparam int DW = 3 + 2 * OUT_W + PW;
  localparam logic [DW-1:0] RST_VAL = {2'b00, {(2 * OUT_W){1'b0}},
                                       PW'(1) << MIN_LOG2_PTS, 1'b0};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      len_q, len_d;
  logic            inv_q, inv_d;
  logic [15:0]     frame_q, frame_d;

  logic            stage_free;
  logic            ld_valid, ld_sop, ld_eop;
  logic [OUT_W-1:0] ld_real;
  logic [DW-1:0]   ld_data, out_data;
  logic [PW-1:0]   len_pts, last_idx;
  logic            at_last;

  assign len_pts  = PW'(1) << len_q;
  assign last_idx = len_pts - PW'(1);
  assign at_last  = {1'b0, cnt_q} == last_idx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    inv_d    = inv_q;
    frame_d  = frame_q;
    ld_valid = 1'b0;
    ld_sop   = 1'b0;
    ld_eop   = 1'b0;
    ld_real  = '0;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stage_free) begin
          len_d   = clamp_log2(cfg_log2_pts, 4'(MIN_LOG2_PTS), 4'(MAX_LOG2_PTS));
          inv_d   = cfg_inverse;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        in_ready = stage_free;
        if (in_valid && stage_free) begin
          ld_valid = 1'b1;
          ld_sop   = cnt_q == '0;
          ld_eop   = at_last;
          ld_real  = OUT_W'($signed(in_data));
          if (at_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            frame_d = frame_q + 16'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // A frame that just closed on eop ignores the flush.
        if (flush && cnt_q != '0 && state_d == STREAM) state_d = PAD;
      end
      PAD: begin
        if (stage_free) begin
          ld_valid = 1'b1;
          ld_eop   = at_last;
          if (at_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            frame_d = frame_q + 16'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= 4'(MIN_LOG2_PTS);
      inv_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      inv_q   <= inv_d;
      frame_q <= frame_d;
    end
  end

  assign ld_data = {ld_sop, ld_eop, ld_real, {OUT_W{1'b0}}, len_pts, inv_q};

  st_out_reg #(
    .W       (DW),
    .RST_VAL (RST_VAL)
  ) u_out (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .stage_free (stage_free),
    .out_valid  (sink_valid),
    .out_ready  (sink_ready),
    .out_data   (out_data)
  );

  assign {sink_sop, sink_eop, sink_real, sink_imag, sink_fftpts, sink_inverse} = out_data;
  assign frame_count = frame_q;
  assign busy        = (state_q != IDLE) || sink_valid;

endmodule
